// File: rtl/election_bonus_timer.sv
// ---------------------------------------------------------------------------
// election_bonus_timer
//   Grants each tank a timed shield power-up on its bonus pulse. The shield
//   is counted down in start-of-frame ticks. During the last WARN_SEC seconds
//   the shield drawing blinks. Two identical, independent channels.
//
// Ports
//   clk, reset            clock, async active-high reset
//   start_of_frame        one-cycle pulse per video frame
//   tank1Bonus/tank2Bonus one-cycle shield grant pulse
//   tank1Dead/tank2Dead   level, cancels that tank's shield
//   tankNShield           shield functionally active (to hit logic)
//   tankNShieldDraw       shield sprite draw enable (blinks in warn)
//   tankNSecLeft[4:0]     whole seconds remaining, 0 when idle
// ---------------------------------------------------------------------------
module election_bonus_channel #(
    parameter int BONUS_SEC   = 10,
    parameter int WARN_SEC    = 3,
    parameter int SOF_PER_SEC = 30,
    parameter int BLINK_SOF   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sof,
    input  logic       bonus,
    input  logic       dead,
    output logic       shield,
    output logic       shield_draw,
    output logic [4:0] sec_left
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        WARN   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] frame_cnt_q, frame_cnt_d;
    logic [4:0] sec_left_q, sec_left_d;
    logic [5:0] blink_cnt_q, blink_cnt_d;
    logic       blink_phase_q, blink_phase_d;
    logic [4:0] sec_dec;

    assign sec_dec = sec_left_q - 5'd1;

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        sec_left_d    = sec_left_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        if (dead) begin
            // Dead outranks a same-cycle bonus: the grant is discarded.
            state_d       = IDLE;
            frame_cnt_d   = '0;
            sec_left_d    = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (bonus) begin
            // Load outranks a same-cycle SOF, so that SOF is not counted.
            state_d       = (BONUS_SEC <= WARN_SEC) ? WARN : ACTIVE;
            frame_cnt_d   = '0;
            sec_left_d    = 5'(BONUS_SEC);
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (sof && (state_q != IDLE)) begin
            // Blink runs only while already in WARN; entry SOF leaves it at 0/1.
            if (state_q == WARN) begin
                if (blink_cnt_q == 6'(BLINK_SOF - 1)) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 6'd1;
                end
            end

            if (frame_cnt_q == 6'(SOF_PER_SEC - 1)) begin
                frame_cnt_d = '0;
                sec_left_d  = sec_dec;
                if (sec_dec == 5'd0) begin
                    state_d       = IDLE;
                    blink_cnt_d   = '0;
                    blink_phase_d = 1'b1;
                end else if (sec_dec <= 5'(WARN_SEC)) begin
                    state_d = WARN;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            frame_cnt_q   <= '0;
            sec_left_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            sec_left_q    <= sec_left_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Pure decode of flop outputs; async reset clears them without delay.
    assign shield      = (state_q != IDLE);
    assign shield_draw = (state_q == ACTIVE) || ((state_q == WARN) && blink_phase_q);
    assign sec_left    = (state_q == IDLE) ? 5'd0 : sec_left_q;

endmodule

module election_bonus_timer #(
    parameter int BONUS_SEC   = 10,
    parameter int WARN_SEC    = 3,
    parameter int SOF_PER_SEC = 30,
    parameter int BLINK_SOF   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_of_frame,
    input  logic       tank1Bonus,
    input  logic       tank2Bonus,
    input  logic       tank1Dead,
    input  logic       tank2Dead,
    output logic       tank1Shield,
    output logic       tank2Shield,
    output logic       tank1ShieldDraw,
    output logic       tank2ShieldDraw,
    output logic [4:0] tank1SecLeft,
    output logic [4:0] tank2SecLeft
);

    election_bonus_channel #(
        .BONUS_SEC  (BONUS_SEC),
        .WARN_SEC   (WARN_SEC),
        .SOF_PER_SEC(SOF_PER_SEC),
        .BLINK_SOF  (BLINK_SOF)
    ) u_tank1 (
        .clk        (clk),
        .reset      (reset),
        .sof        (start_of_frame),
        .bonus      (tank1Bonus),
        .dead       (tank1Dead),
        .shield     (tank1Shield),
        .shield_draw(tank1ShieldDraw),
        .sec_left   (tank1SecLeft)
    );

    election_bonus_channel #(
        .BONUS_SEC  (BONUS_SEC),
        .WARN_SEC   (WARN_SEC),
        .SOF_PER_SEC(SOF_PER_SEC),
        .BLINK_SOF  (BLINK_SOF)
    ) u_tank2 (
        .clk        (clk),
        .reset      (reset),
        .sof        (start_of_frame),
        .bonus      (tank2Bonus),
        .dead       (tank2Dead),
        .shield     (tank2Shield),
        .shield_draw(tank2ShieldDraw),
        .sec_left   (tank2SecLeft)
    );

endmodule

// File: tb/tb_election_bonus_timer.sv
// ---------------------------------------------------------------------------
// tb_election_bonus_timer
//   Directed bench with SOF_PER_SEC=4, BONUS_SEC=3, WARN_SEC=1, BLINK_SOF=2.
//   Inputs change on the falling edge; outputs are sampled 1 time unit after
//   the rising edge.
// ---------------------------------------------------------------------------
module tb_election_bonus_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_of_frame = 1'b0;
    logic       tank1Bonus = 1'b0;
    logic       tank2Bonus = 1'b0;
    logic       tank1Dead = 1'b0;
    logic       tank2Dead = 1'b0;
    logic       tank1Shield, tank2Shield;
    logic       tank1ShieldDraw, tank2ShieldDraw;
    logic [4:0] tank1SecLeft, tank2SecLeft;

    int tests = 0;
    int fails = 0;

    // Expected tank state after SOF i (1..12) of an uninterrupted grant.
    logic [4:0] exp_sec  [1:12] = '{5'd3, 5'd3, 5'd3, 5'd2, 5'd2, 5'd2,
                                     5'd2, 5'd1, 5'd1, 5'd1, 5'd1, 5'd0};
    logic       exp_draw [1:12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    election_bonus_timer #(
        .BONUS_SEC  (3),
        .WARN_SEC   (1),
        .SOF_PER_SEC(4),
        .BLINK_SOF  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (start_of_frame),
        .tank1Bonus     (tank1Bonus),
        .tank2Bonus     (tank2Bonus),
        .tank1Dead      (tank1Dead),
        .tank2Dead      (tank2Dead),
        .tank1Shield    (tank1Shield),
        .tank2Shield    (tank2Shield),
        .tank1ShieldDraw(tank1ShieldDraw),
        .tank2ShieldDraw(tank2ShieldDraw),
        .tank1SecLeft   (tank1SecLeft),
        .tank2SecLeft   (tank2SecLeft)
    );

    task automatic cyc(input logic sof, input logic b1, input logic b2);
        @(negedge clk);
        start_of_frame = sof;
        tank1Bonus     = b1;
        tank2Bonus     = b2;
        @(posedge clk);
        #1;
    endtask

    // Each SOF followed by a quiet cycle, so idle cycles are exercised too.
    task automatic sofs(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic chk1(input string tag, input logic sh, input logic dr, input logic [4:0] sec);
        tests++;
        assert ({tank1Shield, tank1ShieldDraw, tank1SecLeft} === {sh, dr, sec})
        else begin
            fails++;
            $error("FAIL %s tank1 observed sh=%b dr=%b sec=%0d expected sh=%b dr=%b sec=%0d",
                   tag, tank1Shield, tank1ShieldDraw, tank1SecLeft, sh, dr, sec);
        end
    endtask

    task automatic chk2(input string tag, input logic sh, input logic dr, input logic [4:0] sec);
        tests++;
        assert ({tank2Shield, tank2ShieldDraw, tank2SecLeft} === {sh, dr, sec})
        else begin
            fails++;
            $error("FAIL %s tank2 observed sh=%b dr=%b sec=%0d expected sh=%b dr=%b sec=%0d",
                   tag, tank2Shield, tank2ShieldDraw, tank2SecLeft, sh, dr, sec);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("reset", 1'b0, 1'b0, 5'd0);
        chk2("reset", 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        reset = 1'b0;

        // No bonus: SOFs alone change nothing
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk1("idle_sof", 1'b0, 1'b0, 5'd0);
            chk2("idle_sof", 1'b0, 1'b0, 5'd0);
        end

        // Full countdown on tank 1
        cyc(1'b0, 1'b1, 1'b0);
        chk1("load", 1'b1, 1'b1, 5'd3);
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk1($sformatf("count_sof%0d", i), (i < 12), exp_draw[i], exp_sec[i]);
            chk2("count_t2_idle", 1'b0, 1'b0, 5'd0);
            cyc(1'b0, 1'b0, 1'b0);
            chk1($sformatf("count_gap%0d", i), (i < 12), exp_draw[i], exp_sec[i]);
        end

        // Asynchronous reset mid-countdown clears outputs within the cycle
        cyc(1'b0, 1'b1, 1'b0);
        sofs(5);
        chk1("pre_reset", 1'b1, 1'b1, 5'd2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk1("async_reset", 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        chk1("after_reset", 1'b0, 1'b0, 5'd0);

        // Re-grant during WARN restarts the full duration
        cyc(1'b0, 1'b1, 1'b0);
        sofs(10);
        chk1("warn_low", 1'b1, 1'b0, 5'd1);
        cyc(1'b0, 1'b1, 1'b0);
        chk1("regrant", 1'b1, 1'b1, 5'd3);
        sofs(11);
        chk1("regrant_11", 1'b1, 1'b0, 5'd1);
        sofs(1);
        chk1("regrant_12", 1'b0, 1'b0, 5'd0);

        // Dead beats bonus while idle
        tank1Dead = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        chk1("dead_bonus", 1'b0, 1'b0, 5'd0);
        tank1Dead = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        chk1("dead_bonus_after", 1'b0, 1'b0, 5'd0);

        // Dead during WARN cancels the shield next cycle
        cyc(1'b0, 1'b1, 1'b0);
        sofs(9);
        chk1("pre_dead_warn", 1'b1, 1'b1, 5'd1);
        @(negedge clk);
        tank1Dead = 1'b1;
        @(posedge clk);
        #1;
        chk1("dead_warn", 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        tank1Dead = 1'b0;
        sofs(2);
        chk1("dead_warn_after", 1'b0, 1'b0, 5'd0);

        // Bonus coincident with SOF: that SOF is not counted
        cyc(1'b1, 1'b1, 1'b0);
        chk1("coincident_load", 1'b1, 1'b1, 5'd3);
        sofs(3);
        chk1("coincident_3", 1'b1, 1'b1, 5'd3);
        sofs(8);
        chk1("coincident_11", 1'b1, 1'b0, 5'd1);
        sofs(1);
        chk1("coincident_12", 1'b0, 1'b0, 5'd0);

        // Both tanks granted together, tank 2 re-granted 5 SOFs later
        cyc(1'b0, 1'b1, 1'b1);
        chk1("both_load", 1'b1, 1'b1, 5'd3);
        chk2("both_load", 1'b1, 1'b1, 5'd3);
        sofs(5);
        chk1("both_5", 1'b1, 1'b1, 5'd2);
        chk2("both_5", 1'b1, 1'b1, 5'd2);
        cyc(1'b0, 1'b0, 1'b1);
        chk1("t2_regrant", 1'b1, 1'b1, 5'd2);
        chk2("t2_regrant", 1'b1, 1'b1, 5'd3);
        sofs(6);
        chk1("both_11", 1'b1, 1'b0, 5'd1);
        chk2("both_11", 1'b1, 1'b1, 5'd2);
        sofs(1);
        chk1("both_12", 1'b0, 1'b0, 5'd0);
        chk2("both_12", 1'b1, 1'b1, 5'd2);
        sofs(4);
        chk2("both_16", 1'b1, 1'b0, 5'd1);
        sofs(1);
        chk2("both_17", 1'b0, 1'b0, 5'd0);
        chk1("both_17", 1'b0, 1'b0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/election_bonus_timer.md
# election_bonus_timer

Downstream consumer of the election-house counter's `tank1Bonus`/`tank2Bonus` pulses. On each pulse it grants that tank a timed shield power-up, counted down in start-of-frame ticks. It exposes:
- shield-active flags to the collision/hit logic;
- a blinking shield-draw enable to the drawing layer;
- seconds remaining, per tank, to the score/HUD display.

## Interface
Parameters:
- `BONUS_SEC`, 10, shield duration in seconds; legal range 1..31.
- `WARN_SEC`, 3, final seconds during which the shield drawing blinks; legal range 0..`BONUS_SEC`.
- `SOF_PER_SEC`, 30, start_of_frame pulses per second; legal range 2..63.
- `BLINK_SOF`, 8, SOFs per blink half-period in warn; legal range 1..63.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset; one clock domain only.
- `start_of_frame`  in  1  one-cycle pulse per video frame.
- `tank1Bonus`  in  1  one-cycle grant pulse for tank 1.
- `tank2Bonus`  in  1  one-cycle grant pulse for tank 2.
- `tank1Dead`  in  1  level; tank 1 destroyed, cancels its shield.
- `tank2Dead`  in  1  level; tank 2 destroyed, cancels its shield.
- `tank1Shield`  out  1  tank 1 shield functionally active.
- `tank2Shield`  out  1  tank 2 shield functionally active.
- `tank1ShieldDraw`  out  1  draw enable for tank 1's shield sprite.
- `tank2ShieldDraw`  out  1  draw enable for tank 2's shield sprite.
- `tank1SecLeft`  out  5  tank 1 whole seconds remaining; 0 when idle.
- `tank2SecLeft`  out  5  tank 2 whole seconds remaining; 0 when idle.

## Operation
- Two independent, identical per-tank channels. Tank 1 is described; tank 2 mirrors it.
- Per-channel state machine: IDLE, ACTIVE, WARN.
  - IDLE -> ACTIVE on a bonus pulse.
  - ACTIVE -> WARN when `secLeft` <= `WARN_SEC` after a decrement, or immediately on load if `BONUS_SEC` <= `WARN_SEC`.
  - ACTIVE/WARN -> IDLE when `secLeft` reaches 0, or when Dead is sampled high.
- Per-channel registers:
  - `frameCnt`, 6 bits, range 0..`SOF_PER_SEC`-1.
  - `secLeft`, 5 bits.
  - `blinkCnt`, 6 bits.
  - `blinkPhase`, 1 bit.
- Load, on a bonus pulse in any state:
  - `secLeft` <= `BONUS_SEC`, `frameCnt` <= 0, `blinkCnt` <= 0, `blinkPhase` <= 1.
  - A pulse while ACTIVE/WARN restarts the full duration. No stacking.
- Countdown, on each SOF in ACTIVE/WARN with no load that cycle:
  - `frameCnt` increments.
  - At `SOF_PER_SEC`-1, `frameCnt` wraps to 0 and `secLeft` decrements.
  - A decrement to 0 goes to IDLE.
- Blink, on each SOF in WARN:
  - `blinkCnt` increments.
  - At `BLINK_SOF`-1, `blinkCnt` wraps to 0 and `blinkPhase` toggles.
  - `blinkCnt`/`blinkPhase` are held at 0/1 outside WARN.
- Outputs:
  - Shield = (state != IDLE).
  - ShieldDraw = ACTIVE, or (WARN and `blinkPhase`).
  - SecLeft = `secLeft`; forced to 0 in IDLE.
- Priority within one cycle: Dead > Bonus > SOF countdown.
  - Dead and Bonus in the same cycle: channel goes or stays IDLE and the bonus is discarded.
  - Bonus and SOF in the same cycle: load wins, and that SOF is not counted.
- Bonus pulses on both tanks in the same cycle: both channels load independently.

## Timing
- Reset: all outputs 0; all states IDLE; all counters 0; `blinkPhase` 1. Reset is asserted asynchronously and released synchronously to `clk` externally.
- Reset mid-countdown clears the channel immediately, with no cycle delay on the outputs.
- All outputs are registered. Bonus pulse in cycle t -> Shield=1, ShieldDraw=1, SecLeft=`BONUS_SEC` in cycle t+1.
- Dead high in cycle t -> Shield=0, ShieldDraw=0, SecLeft=0 in cycle t+1.
- Total shield lifetime after load = exactly `BONUS_SEC`*`SOF_PER_SEC` SOF pulses. Shield falls the cycle after the final SOF.
- WARN entry coincides with the SOF that decrements `secLeft` to `WARN_SEC`. ShieldDraw's first low phase begins `BLINK_SOF` SOFs later.
- Non-SOF cycles never change the counters.

## Test plan
Directed scenarios use `SOF_PER_SEC`=4, `BONUS_SEC`=3, `WARN_SEC`=1, `BLINK_SOF`=2 unless stated.
- Reset, then 20 SOFs with no bonus -> all outputs stay 0. Assert reset mid-countdown -> outputs 0 within the same cycle.
- tank1Bonus pulse, then SOFs -> SecLeft goes 3,2,1 at SOF 0,4,8; WARN from SOF 8; ShieldDraw low after SOF 10; Shield falls after SOF 12. Tank 2 outputs stay 0 throughout.
- Re-grant at SecLeft=1 -> SecLeft=3 next cycle, ShieldDraw=1, and the full 12 SOFs are needed to expire.
- tank1Dead and tank1Bonus in the same cycle while IDLE -> stays IDLE. Dead asserted during WARN -> all tank 1 outputs 0 next cycle.
- Bonus coincident with SOF -> SOF not counted: expiry takes 12 further SOFs, i.e. 13 total including the coincident one.
- Both bonus pulses in the same cycle, then tank2 re-granted 5 SOFs later -> tank 1 expires at SOF 12, tank 2 at SOF 17; counts are independent.
